// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator with byte enables, a timeout watchdog and an optional misalignment trap.
// Latency: at least 2 cycles from acceptance to the wb_valid/mem_err pulse, plus 1 per dmem wait cycle; one access per 3 cycles at best.
// Backpressure: mem_stall freezes IF..EX/MEM while the access is outstanding; dmem_req is held, with stable attributes, until dmem_ready.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ex_*                         memory instruction from the EX/MEM register (read wins over write)
//   mem_stall                    combinational pipeline freeze
//   wb_valid, wb_data            completion pulse and extended load data (0 for stores)
//   mem_err, mem_misalign        one-cycle timeout / misalignment-trap pulses
//   dmem_*                       word-addressed data memory port with byte enables
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them.
module mem_access_ctrl #(
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ex_valid,
    input  logic                       ex_mem_read,
    input  logic                       ex_mem_write,
    input  logic [2:0]                 ex_funct3,
    input  logic [REG_WIDTH-1:0]       ex_alu_out,
    input  logic [REG_WIDTH-1:0]       ex_dataB,
    output logic                       mem_stall,
    output logic                       wb_valid,
    output logic [REG_WIDTH-1:0]       wb_data,
    output logic                       mem_err,
    output logic                       mem_misalign,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]                 dmem_be,
    output logic [REG_WIDTH-1:0]       dmem_wdata,
    input  logic                       dmem_ready,
    input  logic [REG_WIDTH-1:0]       dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Size encoding shared by the store packer and the load extender.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Counter value seen on the last ACCESS cycle allowed to wait for dmem_ready.
    localparam logic [7:0] LP_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_wait_cnt;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [1:0]      r_off;
    logic            r_load;

    logic            w_accept;
    logic [1:0]      w_size_in;
    logic [1:0]      w_off_in;
    logic [1:0]      w_off_eff;
    logic            w_misalign_in;
    logic            w_trap;
    logic            w_ready_done;
    logic            w_timeout;
    logic [3:0]      w_be_in;
    logic [REG_WIDTH-1:0] w_wdata_in;
    logic [7:0]      w_lane_byte;
    logic [15:0]     w_lane_half;
    logic [REG_WIDTH-1:0] w_load_ext;
    logic            w_unused;

    // reset_n gates acceptance so the pipeline is never frozen while held in reset.
    assign w_accept  = reset_n && (r_state == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);

    // funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 fall into word).
    assign w_size_in = ex_funct3[1] ? SZ_WORD : {1'b0, ex_funct3[0]};
    assign w_off_in  = ex_alu_out[1:0];

    assign w_misalign_in = ((w_size_in == SZ_HALF) && w_off_in[0]) ||
                           ((w_size_in == SZ_WORD) && (w_off_in != 2'b00));

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_misalign_in;
`else
    assign w_trap = 1'b0;
`endif

    // Offset forced onto the natural boundary of the access size; only
    // observable when the trap is disabled, otherwise such accesses never issue.
    always_comb begin
        w_off_eff = 2'b00;
        case (w_size_in)
            SZ_BYTE: w_off_eff = w_off_in;
            SZ_HALF: w_off_eff = {w_off_in[1], 1'b0};
            default: w_off_eff = 2'b00;
        endcase
    end

    // Store lanes: data replicated across the word, byte enables pick the lane.
    always_comb begin
        w_be_in    = 4'b1111;
        w_wdata_in = '0;
        if (!ex_mem_read) begin
            case (w_size_in)
                SZ_BYTE: begin
                    w_be_in    = 4'b0001 << w_off_eff;
                    w_wdata_in = {4{ex_dataB[7:0]}};
                end
                SZ_HALF: begin
                    w_be_in    = 4'b0011 << w_off_eff;
                    w_wdata_in = {2{ex_dataB[15:0]}};
                end
                default: begin
                    w_be_in    = 4'b1111;
                    w_wdata_in = ex_dataB;
                end
            endcase
        end
    end

    // Load lane select and extension from the latched size/offset.
    always_comb begin
        w_lane_byte = 8'(dmem_rdata >> {r_off, 3'b000});
        w_lane_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_ext  = dmem_rdata;
        case (r_size)
            SZ_BYTE: w_load_ext = r_unsigned ? {{(REG_WIDTH-8){1'b0}}, w_lane_byte}
                                             : {{(REG_WIDTH-8){w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: w_load_ext = r_unsigned ? {{(REG_WIDTH-16){1'b0}}, w_lane_half}
                                             : {{(REG_WIDTH-16){w_lane_half[15]}}, w_lane_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the combinational stall.
    always_comb begin
        w_next_state = r_state;
        w_ready_done = 1'b0;
        w_timeout    = 1'b0;
        mem_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    mem_stall    = 1'b1;
                    w_next_state = w_trap ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                // A late dmem_ready on the final allowed cycle still completes normally.
                if (dmem_ready) begin
                    w_ready_done = 1'b1;
                    w_next_state = DONE;
                end else if (r_wait_cnt == LP_TIMEOUT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request attributes, wait counter and result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_load     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            mem_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_accept) begin
                        r_size     <= w_size_in;
                        r_unsigned <= ex_funct3[2];
                        r_off      <= w_off_eff;
                        r_load     <= ex_mem_read;
                        dmem_we    <= ~ex_mem_read;
                        dmem_addr  <= ex_alu_out[DMEM_ADDR_WIDTH+1:2];
                        dmem_be    <= w_be_in;
                        dmem_wdata <= w_wdata_in;
                        dmem_req   <= ~w_trap;
                    end
                end
                ACCESS: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    if (w_ready_done) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= r_load ? w_load_ext : '0;
                    end else if (w_timeout) begin
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                    end
                end
                default: begin
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_misalign <= 1'b0;
        end else begin
            mem_misalign <= w_accept && w_trap;
        end
    end
`else
    assign mem_misalign = 1'b0;
`endif

    // Address bits above the data memory's reach are intentionally dropped.
    assign w_unused = ^{ex_alu_out[REG_WIDTH-1:DMEM_ADDR_WIDTH+2], w_misalign_in};

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_alu_out = 32'h0;
    logic [31:0] ex_dataB = 32'h0;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        mem_err;
    logic        mem_misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h5A5A_5A5A;

    mem_access_ctrl #(
        .REG_WIDTH       (32),
        .DMEM_ADDR_WIDTH (10),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_alu_out   (ex_alu_out),
        .ex_dataB     (ex_dataB),
        .mem_stall    (mem_stall),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .mem_err      (mem_err),
        .mem_misalign (mem_misalign),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    // {wb_valid, mem_err, mem_misalign, wb_data} as seen in the completion cycle.
    typedef struct packed {
        logic        wbv;
        logic        err;
        logic        mis;
        logic [31:0] data;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int          obs_stalls;
    int          obs_done_k;
    logic        obs_req_seen;
    logic        obs_req_at_done;
    logic        obs_we;
    logic [9:0]  obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    res_t        obs_res;

    function automatic res_t mk(input logic wbv, input logic err, input logic mis, input logic [31:0] d);
        res_t r;
        r.wbv  = wbv;
        r.err  = err;
        r.mis  = mis;
        r.data = d;
        return r;
    endfunction

    // Presents one instruction for a single cycle (cycle T), then plays the
    // memory: dmem_ready is raised on ACCESS cycle wait_n+1 (never if wait_n<0).
    // Observation k counts cycles after T; stops at the first result pulse.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int wait_n, input logic [31:0] rdata, input int max_k);
        @(posedge clk);
        #1;
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_alu_out   = addr;
        ex_dataB     = data;
        obs_stalls      = 0;
        obs_done_k      = -1;
        obs_req_seen    = 1'b0;
        obs_req_at_done = 1'b0;
        obs_we          = 1'b0;
        obs_addr        = '0;
        obs_be          = '0;
        obs_wdata       = '0;
        obs_res         = '0;
        @(negedge clk);
        if (mem_stall) obs_stalls++;
        for (int k = 1; k <= max_k; k++) begin
            @(posedge clk);
            #1;
            ex_valid     = 1'b0;
            ex_mem_read  = 1'b0;
            ex_mem_write = 1'b0;
            dmem_ready   = 1'b0;
            dmem_rdata   = 32'h5A5A_5A5A;
            @(negedge clk);
            if (mem_stall) obs_stalls++;
            if (dmem_req && !obs_req_seen) begin
                obs_req_seen = 1'b1;
                obs_we       = dmem_we;
                obs_addr     = dmem_addr;
                obs_be       = dmem_be;
                obs_wdata    = dmem_wdata;
            end
            if (wb_valid || mem_err || mem_misalign) begin
                obs_done_k      = k;
                obs_res         = {wb_valid, mem_err, mem_misalign, wb_data};
                obs_req_at_done = dmem_req;
                break;
            end
            if (dmem_req && (k == wait_n + 1)) begin
                dmem_ready = 1'b1;
                dmem_rdata = rdata;
            end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_dmem: got req=%b we=%b addr=%h be=%b wdata=%h, expected all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        n_checks++;
        if ({wb_valid, wb_data, mem_err, mem_misalign, mem_stall} !== '0) begin
            n_errors++;
            $display("FAIL reset_wb: got wbv=%b data=%h err=%b mis=%b stall=%b, expected all 0",
                     wb_valid, wb_data, mem_err, mem_misalign, mem_stall);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_store();
        res_t e;
        // SB to 0x13: word 4, top lane, byte replicated.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0));
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL sb_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if (obs_done_k !== 2) begin n_errors++; $display("FAIL sb_latency: got %0d expected 2", obs_done_k); end
        n_checks++;
        if ({obs_req_seen, obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 1'b1, 10'h004, 4'b1000, 32'hA5A5_A5A5}) begin
            n_errors++;
            $display("FAIL sb_attrs: got req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 004 1000 a5a5a5a5",
                     obs_req_seen, obs_we, obs_addr, obs_be, obs_wdata);
        end
        n_checks++;
        if (obs_stalls !== 2) begin n_errors++; $display("FAIL sb_stall: got %0d expected 2", obs_stalls); end

        // SH to 0x22: word 8, upper half lanes.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0));
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_BEEF, 1, 32'h0, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL sh_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 10'h008, 4'b1100, 32'hBEEF_BEEF}) begin
            n_errors++;
            $display("FAIL sh_attrs: got we=%b addr=%h be=%b wdata=%h expected 1 008 1100 beefbeef",
                     obs_we, obs_addr, obs_be, obs_wdata);
        end

        // SW to 0x40.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0));
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL sw_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 10'h010, 4'b1111, 32'hDEAD_BEEF}) begin
            n_errors++;
            $display("FAIL sw_attrs: got we=%b addr=%h be=%b wdata=%h expected 1 010 1111 deadbeef",
                     obs_we, obs_addr, obs_be, obs_wdata);
        end
    endtask

    task automatic test_load_byte();
        res_t e;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'hFFFF_FF80));
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0052, 32'h0, 0, 32'h0080_0000, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL lb_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if ({obs_we, obs_addr, obs_be} !== {1'b0, 10'h014, 4'b1111}) begin
            n_errors++;
            $display("FAIL lb_attrs: got we=%b addr=%h be=%b expected 0 014 1111", obs_we, obs_addr, obs_be);
        end
        // LBU, with ex_mem_write also set: read takes priority.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_0080));
        run_access(1'b1, 1'b1, 3'b100, 32'h0000_0052, 32'h0, 0, 32'h0080_0000, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL lbu_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if (obs_we !== 1'b0) begin n_errors++; $display("FAIL lbu_we: got %b expected 0", obs_we); end
    endtask

    task automatic test_load_half_wait();
        res_t e;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'hFFFF_8001));
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 3, 32'h8001_1234, 12);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL lh_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if (obs_done_k !== 5) begin n_errors++; $display("FAIL lh_latency: got %0d expected 5", obs_done_k); end
        n_checks++;
        if (obs_stalls !== 5) begin n_errors++; $display("FAIL lh_stall: got %0d expected 5", obs_stalls); end
        // LHU low lane, plus a word-class funct3 (111) that must not extend.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_8234));
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 1, 32'h8001_8234, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL lhu_result: got %h expected %h", obs_res, e); end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h8000_0000));
        run_access(1'b1, 1'b0, 3'b111, 32'h0000_0104, 32'h0, 0, 32'h8000_0000, 10);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL f3_111_result: got %h expected %h", obs_res, e); end
    endtask

    task automatic test_timeout();
        res_t e;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0));
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, -1, 32'h0, 12);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL to_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if (obs_done_k !== TO + 1) begin n_errors++; $display("FAIL to_latency: got %0d expected %0d", obs_done_k, TO + 1); end
        n_checks++;
        if (obs_req_at_done !== 1'b0) begin n_errors++; $display("FAIL to_req_drop: got %b expected 0", obs_req_at_done); end
        // Ready on the last allowed ACCESS cycle wins over the timeout.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h1357_9BDF));
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, TO - 1, 32'h1357_9BDF, 12);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL to_edge_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if (obs_done_k !== TO + 1) begin n_errors++; $display("FAIL to_edge_latency: got %0d expected %0d", obs_done_k, TO + 1); end
    endtask

    task automatic test_misalign();
        res_t e;
`ifdef MEM_MISALIGN_TRAP_EN
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0));
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'hCAFE_F00D, 8);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL mis_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if (obs_req_seen !== 1'b0) begin n_errors++; $display("FAIL mis_no_req: got %b expected 0", obs_req_seen); end
        n_checks++;
        if (obs_done_k !== 1 || obs_stalls !== 1) begin
            n_errors++;
            $display("FAIL mis_timing: got done=%0d stalls=%0d expected 1 1", obs_done_k, obs_stalls);
        end
`else
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D));
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'hCAFE_F00D, 8);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_res !== e) begin n_errors++; $display("FAIL mis_result: got %h expected %h", obs_res, e); end
        n_checks++;
        if ({obs_addr, obs_be} !== {10'h001, 4'b1111}) begin
            n_errors++;
            $display("FAIL mis_attrs: got addr=%h be=%b expected 001 1111", obs_addr, obs_be);
        end
        // Misaligned half store is pulled down to the aligned half.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0));
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0031, 32'h0000_7788, 0, 32'h0, 8);
        e = exp_q.pop_front();
        n_checks++;
        if ({obs_res, obs_addr, obs_be, obs_wdata} !== {e, 10'h00C, 4'b0011, 32'h7788_7788}) begin
            n_errors++;
            $display("FAIL mis_half_store: got res=%h addr=%h be=%b wdata=%h expected %h 00c 0011 77887788",
                     obs_res, obs_addr, obs_be, obs_wdata, e);
        end
`endif
    endtask

    task automatic test_non_mem();
        run_access(1'b0, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 0, 32'h0, 5);
        n_checks++;
        if (obs_stalls !== 0 || obs_done_k !== -1 || obs_req_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL non_mem: got stalls=%0d done=%0d req=%b expected 0 -1 0",
                     obs_stalls, obs_done_k, obs_req_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(posedge clk);
        #1;
        ex_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_funct3   = 3'b010;
        ex_alu_out  = 32'h0000_0010;
        @(posedge clk);
        #1;
        ex_valid    = 1'b0;
        ex_mem_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_pre: got req=%b stall=%b expected 1 1", dmem_req, mem_stall);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_drop: got req=%b stall=%b expected 0 0", dmem_req, mem_stall);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wb_valid || mem_err || mem_misalign || dmem_req || mem_stall) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_errors++; $display("FAIL rst_mid_after: got activity=%b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_byte();
        test_load_half_wait();
        test_timeout();
        test_misalign();
        test_non_mem();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
